screen_text_sequencer: RTL and testbench

SCREEN_TEXT_SEQUENCER -- requirements
Module: screen_text_sequencer

---
 rtl/screen_text_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_screen_text_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/screen_text_sequencer.sv
// Reveal/blink sequencer driving a chain of string renderers.
// Blinking in SHOW exists only when SCREEN_BLINK_EN is defined.
module screen_text_sequencer #(
  parameter int unsigned       N_STR        = 3,
  parameter int unsigned       REVEAL_TICKS = 1,
  parameter int unsigned       BLINK_TICKS  = 1,
  parameter logic [N_STR-1:0]  BLINK_MASK   =
    N_STR'(1) << (N_STR - 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             module_en,
  input  logic             one_sec_tick,
  input  logic             skip,
  output logic [N_STR-1:0] str_en,
  output logic             reveal_done,
  output logic             state_busy
);

  localparam int unsigned MAXT =
    (REVEAL_TICKS > BLINK_TICKS) ? REVEAL_TICKS
                                 : BLINK_TICKS;
  localparam int unsigned TW = $clog2(MAXT + 1);
  localparam int unsigned CW = $clog2(N_STR + 1);

  localparam logic [CW-1:0] CNT_MAX  = CW'(N_STR);
  localparam logic [TW-1:0] REV_LAST =
    TW'(REVEAL_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REVEAL = 2'd1,
    SHOW   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [N_STR-1:0] str_en_q, str_en_d;
  logic            reveal_done_q, reveal_done_d;
  logic            state_busy_q, state_busy_d;
  logic [N_STR-1:0] revealed;

`ifdef SCREEN_BLINK_EN
  localparam logic [TW-1:0] BLK_LAST =
    TW'(BLINK_TICKS - 1);
  logic phase_q, phase_d;
`else
  // Mask folds to all-ones: every revealed string stays lit.
  localparam logic [N_STR-1:0] STEADY =
    BLINK_MASK | ~BLINK_MASK;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (module_en) begin
          state_d = REVEAL;
        end
      end
      REVEAL: begin
        if (skip || cnt_q == CNT_MAX) begin
          state_d = SHOW;
        end
      end
      SHOW: begin
        state_d = SHOW;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!module_en) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = tick_q;
`ifdef SCREEN_BLINK_EN
    phase_d = phase_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d  = module_en ? CW'(1) : '0;
        tick_d = '0;
`ifdef SCREEN_BLINK_EN
        phase_d = 1'b1;
`endif
      end
      REVEAL: begin
`ifdef SCREEN_BLINK_EN
        phase_d = 1'b1;
`endif
        if (skip) begin
          cnt_d  = CNT_MAX;
          tick_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          tick_d = '0;
        end else if (one_sec_tick) begin
          if (tick_q == REV_LAST) begin
            tick_d = '0;
            cnt_d  = cnt_q + CW'(1);
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      SHOW: begin
`ifdef SCREEN_BLINK_EN
        if (one_sec_tick) begin
          if (tick_q == BLK_LAST) begin
            tick_d  = '0;
            phase_d = ~phase_q;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
`else
        tick_d = '0;
`endif
      end
      default: begin
        cnt_d  = '0;
        tick_d = '0;
      end
    endcase
    if (!module_en) begin
      cnt_d  = '0;
      tick_d = '0;
`ifdef SCREEN_BLINK_EN
      phase_d = 1'b1;
`endif
    end
  end

  always_comb begin
    revealed = '0;
    for (int i = 0; i < int'(N_STR); i++) begin
      revealed[i] = CW'(i) < cnt_d;
    end
`ifdef SCREEN_BLINK_EN
    str_en_d = revealed & (~BLINK_MASK | {N_STR{phase_d}});
`else
    str_en_d = revealed & STEADY;
`endif
    reveal_done_d = (state_q == REVEAL) && (state_d == SHOW);
    state_busy_d  = (state_d == REVEAL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      tick_q        <= '0;
      str_en_q      <= '0;
      reveal_done_q <= 1'b0;
      state_busy_q  <= 1'b0;
`ifdef SCREEN_BLINK_EN
      phase_q       <= 1'b1;
`endif
    end else begin
      cnt_q         <= cnt_d;
      tick_q        <= tick_d;
      str_en_q      <= str_en_d;
      reveal_done_q <= reveal_done_d;
      state_busy_q  <= state_busy_d;
`ifdef SCREEN_BLINK_EN
      phase_q       <= phase_d;
`endif
    end
  end

  assign str_en      = str_en_q;
  assign reveal_done = reveal_done_q;
  assign state_busy  = state_busy_q;

endmodule

// File: tb/tb_screen_text_sequencer.sv
// Bench for screen_text_sequencer: directed table plus
// randomized run against a reference model.
module tb_screen_text_sequencer;

  localparam int N  = 3;
  localparam int RT = 2;
  localparam int BT = 1;
  localparam logic [2:0] MASK = 3'b100;

`ifdef SCREEN_BLINK_EN
  localparam bit BLINK = 1'b1;
  localparam logic [2:0] DIM = 3'b011;
`else
  localparam bit BLINK = 1'b0;
  localparam logic [2:0] DIM = 3'b111;
`endif

  logic       clk = 1'b0;
  logic       rst, module_en, one_sec_tick, skip;
  logic [2:0] str_en;
  logic       reveal_done, state_busy;

  int n_chk  = 0;
  int n_pass = 0;

  screen_text_sequencer #(
    .N_STR(N), .REVEAL_TICKS(RT),
    .BLINK_TICKS(BT), .BLINK_MASK(MASK)
  ) dut (
    .clk(clk), .rst(rst), .module_en(module_en),
    .one_sec_tick(one_sec_tick), .skip(skip),
    .str_en(str_en), .reveal_done(reveal_done),
    .state_busy(state_busy)
  );

  always #5 clk = ~clk;

  // Model: screen mode 0=off 1=revealing 2=showing,
  // number of strings shown, tick count, visibility.
  int m_mode = 0, m_shown = 0, m_ticks = 0;
  bit m_vis = 1'b1, m_done = 1'b0;

  function automatic logic [2:0] m_str();
    logic [2:0] v;
    v = 3'((1 << m_shown) - 1);
    if (BLINK && m_mode == 2 && !m_vis) v = v & ~MASK;
    return v;
  endfunction

  function void model_step(bit r, bit e, bit t, bit s);
    m_done = 1'b0;
    if (r || !e) begin
      m_mode = 0; m_shown = 0; m_ticks = 0; m_vis = 1'b1;
    end else if (m_mode == 0) begin
      m_mode = 1; m_shown = 1; m_ticks = 0;
    end else if (m_mode == 1) begin
      if (s || m_shown == N) begin
        m_mode = 2; m_shown = N; m_ticks = 0;
        m_vis = 1'b1; m_done = 1'b1;
      end else if (t) begin
        m_ticks++;
        if (m_ticks == RT) begin
          m_ticks = 0; m_shown++;
        end
      end
    end else if (BLINK && t) begin
      m_ticks++;
      if (m_ticks == BT) begin
        m_ticks = 0; m_vis = !m_vis;
      end
    end
  endfunction

  task automatic chk(string nm, logic [2:0] es,
                     logic ed, logic eb);
    n_chk++;
    if (str_en === es && reveal_done === ed &&
        state_busy === eb) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got str_en=%b done=%b busy=%b want %b %b %b",
               nm, str_en, reveal_done, state_busy, es, ed, eb);
    end
  endtask

  task automatic step(bit r, bit e, bit t, bit s);
    rst = r; module_en = e; one_sec_tick = t; skip = s;
    @(posedge clk);
    model_step(r, e, t, s);
    #1;
  endtask

  typedef struct {
    bit r, e, t, s;
    logic [2:0] es;
    bit ed, eb;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b1; module_en = 1'b0;
    one_sec_tick = 1'b0; skip = 1'b0;
    // r e t s  str   done busy
    tbl.push_back('{1,0,0,0, 3'b000, 0, 0}); // reset
    tbl.push_back('{0,0,0,0, 3'b000, 0, 0}); // idle
    tbl.push_back('{0,1,0,0, 3'b001, 0, 1}); // start
    tbl.push_back('{0,1,1,0, 3'b001, 0, 1});
    tbl.push_back('{0,1,1,0, 3'b011, 0, 1}); // 2 ticks
    tbl.push_back('{0,1,0,0, 3'b011, 0, 1});
    tbl.push_back('{0,1,1,0, 3'b011, 0, 1});
    tbl.push_back('{0,1,1,0, 3'b111, 0, 1}); // 4 ticks
    tbl.push_back('{0,1,0,0, 3'b111, 1, 0}); // done
    tbl.push_back('{0,1,0,0, 3'b111, 0, 0});
    tbl.push_back('{0,1,1,0, DIM,    0, 0}); // blink
    tbl.push_back('{0,1,1,0, 3'b111, 0, 0});
    tbl.push_back('{0,1,1,0, DIM,    0, 0});
    tbl.push_back('{0,1,1,0, 3'b111, 0, 0});
    tbl.push_back('{0,1,1,1, DIM,    0, 0}); // skip ign
    tbl.push_back('{1,1,1,0, 3'b000, 0, 0}); // rst SHOW
    tbl.push_back('{0,1,0,0, 3'b001, 0, 1}); // restart
    tbl.push_back('{0,1,1,1, 3'b111, 1, 0}); // skip+tick
    tbl.push_back('{0,1,1,0, DIM,    0, 0});
    tbl.push_back('{0,0,0,0, 3'b000, 0, 0}); // disable
    tbl.push_back('{0,1,0,0, 3'b001, 0, 1});
    tbl.push_back('{0,1,1,0, 3'b001, 0, 1});
    tbl.push_back('{0,1,1,0, 3'b011, 0, 1});
    tbl.push_back('{0,0,1,1, 3'b000, 0, 0}); // drop mid
    tbl.push_back('{0,1,0,0, 3'b001, 0, 1}); // restart
    tbl.push_back('{0,1,1,0, 3'b001, 0, 1});
    tbl.push_back('{1,1,1,1, 3'b000, 0, 0}); // rst REVEAL
    tbl.push_back('{0,0,0,0, 3'b000, 0, 0});
    tbl.push_back('{0,0,1,1, 3'b000, 0, 0}); // idle ign

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, tbl[i].t, tbl[i].s);
      chk($sformatf("vec%0d", i),
          tbl[i].es, tbl[i].ed, tbl[i].eb);
    end

    // Full reveal then quiet: exactly one done pulse.
    begin
      int pulses = 0;
      for (int i = 0; i < 60; i++) begin
        step(0, 1, (i % 10) == 9, 0);
        if (reveal_done) pulses++;
      end
      n_chk++;
      if (pulses == 1 && state_busy == 1'b0) n_pass++;
      else $display("FAIL done_once: got pulses=%0d busy=%b want 1 0",
                    pulses, state_busy);
    end

    for (int i = 0; i < 3000; i++) begin
      bit r, e, t, s;
      r = ($urandom_range(63) == 0);
      e = ($urandom_range(15) != 0);
      t = ($urandom_range(3) == 0);
      s = ($urandom_range(19) == 0);
      step(r, e, t, s);
      chk($sformatf("rand%0d", i), m_str(), m_done,
          m_mode == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
